mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning the number of iteration cycles per operation; fixed at 32 for 32-bit operands.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port Start_mult, input, 1, a request for a signed multiply of A by B.
REQ-005 SHALL have port Start_div, input, 1, a request for a signed divide of A by B.
REQ-006 SHALL have port A, input, 32, the multiplicand or dividend (regA output).
REQ-007 SHALL have port B, input, 32, the multiplier or divisor (regB output).
REQ-008 SHALL have port Busy, output, 1, high while an operation is in progress.
REQ-009 SHALL have port Done, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port Mult_hi, output, 32, product bits 63:32, feeding the HIGH mux mult input.
REQ-011 SHALL have port Mult_lo, output, 32, product bits 31:0, feeding the LOW mux mult input.
REQ-012 SHALL have port Div_hi, output, 32, the remainder, feeding the HIGH mux div input.
REQ-013 SHALL have port Div_lo, output, 32, the quotient, feeding the LOW mux div input.
REQ-014 SHALL have port Div_zero, output, 1, a divide-by-zero flag; present only when the Configuration macro is defined.

Function
REQ-015 SHALL implement the FSM states IDLE, MULT, DIV, FIX, DONE.
REQ-016 In IDLE, a start SHALL be accepted on the rising edge where either start is high: A and B are captured, Busy=1 from the next cycle, and the FSM goes to MULT or DIV.
REQ-017 If Start_mult and Start_div are both high, SHALL give Start_mult priority and ignore Start_div.
REQ-018 SHALL ignore starts in MULT, DIV, FIX and DONE; changes on A or B after capture SHALL NOT affect the result.
REQ-019 MULT SHALL perform radix-2 Booth on two's-complement operands: exactly ITER iterations, 33-bit accumulator, so that 0x80000000 operands are exact.
REQ-020 DIV SHALL perform restoring division on operand magnitudes: exactly ITER iterations, one quotient bit per cycle.
REQ-021 FIX SHALL take one cycle: for a divide, negate the quotient if the operand signs differ and give the remainder the dividend's sign; for a multiply, pass the result through.
REQ-022 FIX SHALL load the results: Mult_hi/Mult_lo only for a multiply, Div_hi/Div_lo only for a divide; the other pair holds its value.
REQ-023 DONE SHALL last one cycle with Done=1 and Busy=0, then return to IDLE.
REQ-024 Latency: Done SHALL be high in the 34th cycle after the accepting edge (ITER + FIX + DONE).
REQ-025 Busy SHALL be 1 exactly in MULT, DIV and FIX.
REQ-026 Results SHALL hold until the next completion of the same operation type.
REQ-027 Division semantics: quotient truncates toward zero and remainder sign equals dividend sign; 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-028 The product SHALL be the full 64-bit signed result; no overflow flag.

Reset
REQ-029 Reset high at any edge SHALL force IDLE, Busy=0, Done=0, all four result outputs 0x00000000 and Div_zero=0, including in the middle of an operation.
REQ-030 A start asserted in the same cycle as Reset SHALL be ignored.
REQ-031 The first start SHALL be accepted on the first edge with Reset low.

Configuration
REQ-032 Macro MULT_DIV_UNIT_DIVZERO_EN: when defined, a divide start with B==0 SHALL go directly to DONE on the next edge with Div_zero=1 for that cycle, and Div_hi/Div_lo SHALL be unchanged.
REQ-033 When defined, Div_zero SHALL be 0 in every other cycle.
REQ-034 When the macro is undefined, the port Div_zero SHALL be absent and a divide by zero SHALL run the full 34 cycles.
REQ-035 With the macro undefined, A>=0 divided by 0 SHALL give quotient 0xFFFFFFFF and remainder A; A<0 divided by 0 SHALL give quotient 0x00000001 and remainder A.

Verification
REQ-036 Start_mult, A=0xFFFFFFFF, B=0xFFFFFFFF -> Done in the 34th cycle; Mult_hi=0x00000000, Mult_lo=0x00000001; Div_hi/Div_lo unchanged.
REQ-037 Start_mult, A=B=0x80000000 -> Mult_hi=0x40000000, Mult_lo=0x00000000.
REQ-038 Start_div, A=0xFFFFFFF9 (-7), B=2 -> Div_lo=0xFFFFFFFD (-3), Div_hi=0xFFFFFFFF (-1); Busy high for 33 cycles.
REQ-039 Start_mult and Start_div both high, A=3, B=5 -> multiply executed with Mult_lo=15; Div outputs unchanged; a Start_div pulsed mid-operation is ignored.
REQ-040 Reset asserted in cycle 10 of a divide -> the next cycle shows Busy=0, Done=0, all outputs 0; no Done pulse appears afterwards.
REQ-041 A=7, B=0, divide -> with the macro: Done on the next cycle, Div_zero=1, Div outputs held; without the macro: Done in cycle 34, Div_lo=0xFFFFFFFF, Div_hi=7.

Source files
------------

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Iterative signed 32x32 multiply (radix-2 Booth) and signed
//            32/32 divide (restoring, on magnitudes) with a sign-fix cycle.
//            Optional macro MULT_DIV_UNIT_DIVZERO_EN adds an early-exit
//            divide-by-zero path and the Div_zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module mult_div_unit #(
  parameter int ITER = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start_mult,
  input  logic        Start_div,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Mult_hi,
  output logic [31:0] Mult_lo,
  output logic [31:0] Div_hi,
  output logic [31:0] Div_lo
`ifdef MULT_DIV_UNIT_DIVZERO_EN
  ,
  output logic        Div_zero
`endif
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(ITER - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MULT = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           is_mult_q, is_mult_d;
  logic           sa_q, sa_d;          // dividend sign
  logic           sb_q, sb_d;          // divisor sign
  // Mult: hi = 33-bit Booth accumulator, lo = multiplier / product low half.
  // Div : hi = partial remainder, lo = dividend magnitude shifting into quotient.
  logic [32:0]    hi_q, hi_d;
  logic [31:0]    lo_q, lo_d;
  logic [31:0]    opnd_q, opnd_d;      // multiplicand, or divisor magnitude
  logic           qm1_q, qm1_d;        // Booth q[-1] bit
  logic [31:0]    mult_hi_q, mult_hi_d;
  logic [31:0]    mult_lo_q, mult_lo_d;
  logic [31:0]    div_hi_q, div_hi_d;
  logic [31:0]    div_lo_q, div_lo_d;
`ifdef MULT_DIV_UNIT_DIVZERO_EN
  logic           dz_q, dz_d;
`endif

  logic [32:0]    m_ext;
  logic [32:0]    booth_acc;
  logic [32:0]    div_sh;
  logic [32:0]    div_sub;
  logic           div_ge;
  logic [31:0]    abs_a;
  logic [31:0]    abs_b;

  // Per-iteration arithmetic shared by the MULT and DIV states
  always_comb begin
    m_ext = {opnd_q[31], opnd_q};
    case ({lo_q[0], qm1_q})
      2'b01:   booth_acc = hi_q + m_ext;
      2'b10:   booth_acc = hi_q - m_ext;
      default: booth_acc = hi_q;
    endcase
    div_sh  = {hi_q[31:0], lo_q[31]};
    div_ge  = (div_sh >= {1'b0, opnd_q});
    div_sub = div_sh - {1'b0, opnd_q};
    abs_a   = A[31] ? (32'd0 - A) : A;
    abs_b   = B[31] ? (32'd0 - B) : B;
  end

  // Next-state and datapath update; every register holds by default
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_mult_d = is_mult_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    qm1_d     = qm1_q;
    mult_hi_d = mult_hi_q;
    mult_lo_d = mult_lo_q;
    div_hi_d  = div_hi_q;
    div_lo_d  = div_lo_q;
`ifdef MULT_DIV_UNIT_DIVZERO_EN
    dz_d      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (Start_mult) begin
          is_mult_d = 1'b1;
          hi_d      = '0;
          lo_d      = B;
          opnd_d    = A;
          qm1_d     = 1'b0;
          state_d   = ST_MULT;
        end else if (Start_div) begin
          is_mult_d = 1'b0;
          sa_d      = A[31];
          sb_d      = B[31];
          hi_d      = '0;
          lo_d      = abs_a;
          opnd_d    = abs_b;
          state_d   = ST_DIV;
`ifdef MULT_DIV_UNIT_DIVZERO_EN
          if (B == 32'd0) begin
            dz_d    = 1'b1;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_MULT: begin
        hi_d  = {booth_acc[32], booth_acc[32:1]};
        lo_d  = {booth_acc[0], lo_q[31:1]};
        qm1_d = lo_q[0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) state_d = ST_FIX;
      end
      ST_DIV: begin
        hi_d  = div_ge ? div_sub : div_sh;
        lo_d  = {lo_q[30:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_mult_q) begin
          mult_hi_d = hi_q[31:0];
          mult_lo_d = lo_q;
        end else begin
          div_lo_d = (sa_q ^ sb_q) ? (32'd0 - lo_q) : lo_q;
          div_hi_d = sa_q ? (32'd0 - hi_q[31:0]) : hi_q[31:0];
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_mult_q <= 1'b0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      qm1_q     <= 1'b0;
      mult_hi_q <= '0;
      mult_lo_q <= '0;
      div_hi_q  <= '0;
      div_lo_q  <= '0;
`ifdef MULT_DIV_UNIT_DIVZERO_EN
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_mult_q <= is_mult_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      qm1_q     <= qm1_d;
      mult_hi_q <= mult_hi_d;
      mult_lo_q <= mult_lo_d;
      div_hi_q  <= div_hi_d;
      div_lo_q  <= div_lo_d;
`ifdef MULT_DIV_UNIT_DIVZERO_EN
      dz_q      <= dz_d;
`endif
    end
  end

  assign Busy    = (state_q == ST_MULT) || (state_q == ST_DIV) || (state_q == ST_FIX);
  assign Done    = (state_q == ST_DONE);
  assign Mult_hi = mult_hi_q;
  assign Mult_lo = mult_lo_q;
  assign Div_hi  = div_hi_q;
  assign Div_lo  = div_lo_q;
`ifdef MULT_DIV_UNIT_DIVZERO_EN
  assign Div_zero = dz_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Table-driven self-checking bench for mult_div_unit, plus
//            hand-written reset and mid-operation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start_mult = 1'b0;
  logic        Start_div = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy, Done;
  logic [31:0] Mult_hi, Mult_lo, Div_hi, Div_lo;
`ifdef MULT_DIV_UNIT_DIVZERO_EN
  logic        Div_zero;
`endif

  mult_div_unit #(.ITER(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start_mult(Start_mult), .Start_div(Start_div),
    .A(A), .B(B), .Busy(Busy), .Done(Done),
    .Mult_hi(Mult_hi), .Mult_lo(Mult_lo), .Div_hi(Div_hi), .Div_lo(Div_lo)
`ifdef MULT_DIV_UNIT_DIVZERO_EN
    , .Div_zero(Div_zero)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        sm;
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic        dz;     // divide by zero vector
    logic        pulse;  // pulse Start_div mid-operation
    logic [31:0] eh;     // expected hi of the updated pair
    logic [31:0] el;     // expected lo of the updated pair
  } vec_t;

  localparam int NV = 13;
  vec_t tv [NV];

  int total = 0;
  int bad = 0;
  logic [31:0] m_mh = '0, m_ml = '0, m_dh = '0, m_dl = '0;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h exp=%h", nm, id, act, exp);
    end
  endtask

  task automatic chk_outs(input int id);
    chk("mult_hi", id, Mult_hi, m_mh);
    chk("mult_lo", id, Mult_lo, m_ml);
    chk("div_hi", id, Div_hi, m_dh);
    chk("div_lo", id, Div_lo, m_dl);
  endtask

  // Launch one operation; return Done latency (0 = never) and Busy cycle count
  task automatic do_op(input logic sm, input logic sd, input logic [31:0] a, input logic [31:0] b,
                       input logic pulse, output int lat, output int busy_cnt);
    @(negedge Clk);
    Reset = 1'b0; Start_mult = sm; Start_div = sd; A = a; B = b;
    @(posedge Clk); #1;
    Start_mult = 1'b0; Start_div = 1'b0; A = $urandom; B = $urandom;
    lat = 0; busy_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      Start_div = pulse && (i == 5);
      if (Busy) busy_cnt++;
      if (Done) begin lat = i; break; end
      @(posedge Clk); #1;
    end
    Start_div = 1'b0;
  endtask

  initial begin
    int lat, bc, exp_lat, exp_bc;
    logic dzm;
    logic seen;

    tv[0]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'h00000001};
    tv[1]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h40000000, 32'h00000000};
    tv[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
    tv[3]  = '{1'b1, 1'b1, 32'h00000003, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 32'h0000000F};
    tv[4]  = '{1'b1, 1'b0, 32'h12345678, 32'hFFFFFFFE, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hDB975310};
    tv[5]  = '{1'b0, 1'b1, 32'd100,      32'd7,        1'b0, 1'b0, 32'h00000002, 32'h0000000E};
    tv[6]  = '{1'b0, 1'b1, 32'd100,      32'hFFFFFFF9, 1'b0, 1'b0, 32'h00000002, 32'hFFFFFFF2};
    tv[7]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h0000000E};
    tv[8]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'h80000000};
    tv[9]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 1'b0, 32'h3FFFFFFF, 32'h00000001};
    tv[10] = '{1'b0, 1'b1, 32'd7,        32'd0,        1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFF};
    tv[11] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd0,        1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000001};
    tv[12] = '{1'b1, 1'b0, 32'hFFFFFFFD, 32'd6,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEE};

    // Reset held with a start request asserted: nothing may start
    Start_mult = 1'b1; A = 32'd3; B = 32'd5;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_busy", 0, {31'd0, Busy}, 32'd0);
    chk("rst_done", 0, {31'd0, Done}, 32'd0);
    chk_outs(0);
`ifdef MULT_DIV_UNIT_DIVZERO_EN
    chk("rst_dz", 0, {31'd0, Div_zero}, 32'd0);
`endif
    @(negedge Clk);
    Reset = 1'b0; Start_mult = 1'b0;
    @(posedge Clk); #1;
    chk("post_rst_busy", 0, {31'd0, Busy}, 32'd0);

    // Directed vector table
    for (int v = 0; v < NV; v++) begin
`ifdef MULT_DIV_UNIT_DIVZERO_EN
      dzm = tv[v].dz;
`else
      dzm = 1'b0;
`endif
      do_op(tv[v].sm, tv[v].sd, tv[v].a, tv[v].b, tv[v].pulse, lat, bc);
      exp_lat = dzm ? 1 : 34;
      exp_bc  = dzm ? 0 : 33;
      if (!dzm) begin
        if (tv[v].sm) begin m_mh = tv[v].eh; m_ml = tv[v].el; end
        else          begin m_dh = tv[v].eh; m_dl = tv[v].el; end
      end
      chk("latency", v, lat, exp_lat);
      chk("busy_cycles", v, bc, exp_bc);
      chk_outs(v);
`ifdef MULT_DIV_UNIT_DIVZERO_EN
      chk("div_zero", v, {31'd0, Div_zero}, {31'd0, dzm});
`endif
      @(posedge Clk); #1;
      chk("done_pulse_width", v, {31'd0, Done}, 32'd0);
    end

    // Reset in cycle 10 of a divide
    @(negedge Clk);
    Start_div = 1'b1; A = 32'd100; B = 32'd3;
    @(posedge Clk); #1;
    Start_div = 1'b0;
    repeat (9) begin @(posedge Clk); #1; end
    Reset = 1'b1;
    @(posedge Clk); #1;
    m_mh = '0; m_ml = '0; m_dh = '0; m_dl = '0;
    chk("midrst_busy", 100, {31'd0, Busy}, 32'd0);
    chk("midrst_done", 100, {31'd0, Done}, 32'd0);
    chk_outs(100);
    @(negedge Clk);
    Reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin @(posedge Clk); #1; if (Done || Busy) seen = 1'b1; end
    chk("midrst_no_done", 100, {31'd0, seen}, 32'd0);

    // Start accepted on the first edge with Reset low
    @(negedge Clk); Reset = 1'b1;
    @(posedge Clk); #1;
    do_op(1'b1, 1'b0, 32'hFFFFFFF9, 32'd3, 1'b0, lat, bc);
    m_mh = 32'hFFFFFFFF; m_ml = 32'hFFFFFFEB;
    chk("first_edge_lat", 101, lat, 34);
    chk_outs(101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
